mem_ctrl: RTL

Memory controller that answers instruction-fetch requests from the instruction cache and load/store requests from the load-store buffer. It sits between the core and the byte-wide RAM/IO bus, and serialises each request into 1–4 single-byte bus cycles, little-endian. Accepted requests always complete; the load-store port wins arbitration.

---
 rtl/mem_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller for icache fetches and LSB loads/stores
// Optional MEMC_IO_STALL_EN: IO-region writes wait while io_buffer_full is high.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ic_enable,
    input  logic [ADDR_W-1:0] addr_from_ic,
    output logic              ic_valid,
    output logic [31:0]       inst_to_ic,
    input  logic              lsb_enable,
    input  logic              lsb_wr,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [1:0]        lsb_len,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_valid,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
`ifdef MEMC_IO_STALL_EN
    ,
    input  logic              io_buffer_full
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [1:0]        len, len_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [31:0]       wdata, wdata_n;
    logic              src_lsb, src_lsb_n;
    logic [31:0]       asm_q, asm_n;
    logic [ADDR_W-1:0] mem_a_n;
    logic [7:0]        mem_dout_n;
    logic              mem_wr_q, mem_wr_n;
    logic              ic_valid_n;
    logic [31:0]       inst_n;
    logic              lsb_valid_n;
    logic [31:0]       lsb_rdata_n;

    logic              stall;
    logic [2:0]        nxt_cnt;
    logic [1:0]        cap_idx;
    logic [31:0]       asm_cap;

`ifdef MEMC_IO_STALL_EN
    assign stall = (state == WRITE) && (mem_a[17:16] == 2'b11) && io_buffer_full;
`else
    assign stall = 1'b0;
`endif

    assign mem_wr  = mem_wr_q && !stall;
    assign nxt_cnt = cnt + 3'd1;
    // mem_din seen at count c belongs to the address issued at count c-1
    assign cap_idx = cnt[1:0] - 2'd1;

    always_comb begin
        asm_cap = asm_q;
        asm_cap[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        len_n       = len;
        base_n      = base;
        wdata_n     = wdata;
        src_lsb_n   = src_lsb;
        asm_n       = asm_q;
        mem_a_n     = mem_a;
        mem_dout_n  = mem_dout;
        mem_wr_n    = mem_wr_q;
        ic_valid_n  = 1'b0;
        inst_n      = inst_to_ic;
        lsb_valid_n = 1'b0;
        lsb_rdata_n = lsb_rdata;
        case (state)
            IDLE: begin
                if (lsb_enable) begin
                    base_n    = lsb_addr;
                    len_n     = lsb_len;
                    wdata_n   = lsb_wdata;
                    src_lsb_n = 1'b1;
                    cnt_n     = 3'd0;
                    asm_n     = 32'd0;
                    mem_a_n   = lsb_addr;
                    if (lsb_wr) begin
                        mem_dout_n = lsb_wdata[7:0];
                        mem_wr_n   = 1'b1;
                        state_n    = WRITE;
                    end else begin
                        state_n = READ;
                    end
                end else if (ic_enable) begin
                    base_n    = addr_from_ic;
                    len_n     = 2'd3;
                    src_lsb_n = 1'b0;
                    cnt_n     = 3'd0;
                    asm_n     = 32'd0;
                    mem_a_n   = addr_from_ic;
                    state_n   = READ;
                end
            end
            READ: begin
                cnt_n = nxt_cnt;
                if (cnt != 3'd0) begin
                    asm_n = asm_cap;
                end
                if (cnt < {1'b0, len}) begin
                    mem_a_n = base + ADDR_W'(nxt_cnt);
                end
                if (cnt == {1'b0, len} + 3'd1) begin
                    state_n = DONE;
                    if (src_lsb) begin
                        lsb_valid_n = 1'b1;
                        lsb_rdata_n = asm_cap;
                    end else begin
                        ic_valid_n = 1'b1;
                        inst_n     = asm_cap;
                    end
                end
            end
            WRITE: begin
                if (!stall) begin
                    if (cnt[1:0] == len) begin
                        mem_wr_n    = 1'b0;
                        lsb_valid_n = 1'b1;
                        state_n     = DONE;
                    end else begin
                        cnt_n      = nxt_cnt;
                        mem_a_n    = base + ADDR_W'(nxt_cnt);
                        mem_dout_n = wdata[{nxt_cnt[1:0], 3'b000} +: 8];
                    end
                end
            end
            // the valid cycle itself: requests still held by the requester are ignored
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            len        <= 2'd0;
            base       <= '0;
            wdata      <= 32'd0;
            src_lsb    <= 1'b0;
            asm_q      <= 32'd0;
            mem_a      <= '0;
            mem_dout   <= 8'd0;
            mem_wr_q   <= 1'b0;
            ic_valid   <= 1'b0;
            inst_to_ic <= 32'd0;
            lsb_valid  <= 1'b0;
            lsb_rdata  <= 32'd0;
        end else if (rdy) begin
            state      <= state_n;
            cnt        <= cnt_n;
            len        <= len_n;
            base       <= base_n;
            wdata      <= wdata_n;
            src_lsb    <= src_lsb_n;
            asm_q      <= asm_n;
            mem_a      <= mem_a_n;
            mem_dout   <= mem_dout_n;
            mem_wr_q   <= mem_wr_n;
            ic_valid   <= ic_valid_n;
            inst_to_ic <= inst_n;
            lsb_valid  <= lsb_valid_n;
            lsb_rdata  <= lsb_rdata_n;
        end
    end

endmodule
